// File: rtl/movimento_executor.sv
// Timed H-bridge sequencer behind the movement decoder: continuous forward drive
// plus two-phase manoeuvres with dead time between every direction change.
module movimento_executor #(
  parameter int unsigned T_FASE1 = 4,
  parameter int unsigned T_FASE2 = 3,
  parameter int unsigned T_MORTO = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_frente,
  input  logic       cmd_frente_atras,
  input  logic       cmd_atras_frente,
  output logic       mot_frente,
  output logic       mot_atras,
  output logic       busy,
  output logic       done,
  output logic [2:0] estado
);

  localparam int unsigned T_MAX_12 = (T_FASE1 > T_FASE2) ? T_FASE1 : T_FASE2;
  localparam int unsigned T_MAX    = (T_MAX_12 > T_MORTO) ? T_MAX_12 : T_MORTO;
  localparam int unsigned CW       = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONT_FWD   = 3'd1,
    SEQ_P1     = 3'd2,
    MORTO_MEIO = 3'd3,
    SEQ_P2     = 3'd4,
    MORTO_FIM  = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_dir_fwd, w_dir_nxt;
  logic            r_seq, w_seq_nxt;
  logic            r_mot_f, r_mot_a, r_done;
  logic            w_mot_f_nxt, w_mot_a_nxt, w_done_nxt;
  logic            w_last;

  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir_fwd;
    w_seq_nxt   = r_seq;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_frente_atras) begin
          w_state_nxt = SEQ_P1;
          w_dir_nxt   = 1'b1;
          w_cnt_nxt   = CW'(T_FASE1);
        end else if (cmd_atras_frente) begin
          w_state_nxt = SEQ_P1;
          w_dir_nxt   = 1'b0;
          w_cnt_nxt   = CW'(T_FASE1);
        end else if (cmd_frente) begin
          w_state_nxt = CONT_FWD;
          w_cnt_nxt   = '0;
        end
      end
      CONT_FWD: begin
        if (!cmd_frente || cmd_frente_atras || cmd_atras_frente) begin
          w_state_nxt = MORTO_FIM;
          w_cnt_nxt   = CW'(T_MORTO);
          w_seq_nxt   = 1'b0;
        end
      end
      SEQ_P1: begin
        if (w_last) begin
          w_state_nxt = MORTO_MEIO;
          w_cnt_nxt   = CW'(T_MORTO);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      MORTO_MEIO: begin
        if (w_last) begin
          w_state_nxt = SEQ_P2;
          w_cnt_nxt   = CW'(T_FASE2);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      SEQ_P2: begin
        if (w_last) begin
          w_state_nxt = MORTO_FIM;
          w_cnt_nxt   = CW'(T_MORTO);
          w_seq_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      MORTO_FIM: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = r_seq;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_seq_nxt   = 1'b0;
      end
    endcase

    // Drives are decoded from the next state so they register in step with it.
    w_mot_f_nxt = (w_state_nxt == CONT_FWD) ||
                  ((w_state_nxt == SEQ_P1) && w_dir_nxt) ||
                  ((w_state_nxt == SEQ_P2) && !w_dir_nxt);
    w_mot_a_nxt = ((w_state_nxt == SEQ_P1) && !w_dir_nxt) ||
                  ((w_state_nxt == SEQ_P2) && w_dir_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir_fwd <= 1'b0;
      r_seq     <= 1'b0;
      r_mot_f   <= 1'b0;
      r_mot_a   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir_fwd <= w_dir_nxt;
      r_seq     <= w_seq_nxt;
      r_mot_f   <= w_mot_f_nxt;
      r_mot_a   <= w_mot_a_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign mot_frente = r_mot_f;
  assign mot_atras  = r_mot_a;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);
  assign estado     = r_state;

endmodule
